// File: rtl/dispense_sequencer.sv
// dispense_sequencer: queued route/gate/return sequencing of the sorter and tower gate servos
module dispense_sequencer #(
    parameter int SETTLE_CYCLES = 25000000,
    parameter int DWELL_CYCLES = 50000000,
    parameter int FIFO_DEPTH = 4,
    parameter logic [7:0] HOME = 8'h88,
    parameter logic [7:0] TOW1 = 8'h40,
    parameter logic [7:0] TOW2 = 8'hC0,
    parameter logic [7:0] DISP1 = 8'hFF,
    parameter logic [7:0] RECYC1 = 8'h00,
    parameter logic [7:0] DISP2 = 8'h00,
    parameter logic [7:0] RECYC2 = 8'hFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_data,
    output logic       cmd_ready,
    input  logic       abort,
    output logic [7:0] sv1_pos,
    output logic [7:0] sv2_pos,
    output logic [7:0] sv3_pos,
    output logic       busy,
    output logic       done,
    output logic [2:0] fifo_count,
    output logic [3:0] state_code
);
    localparam logic [2:0] IDLE = 3'd0, ROUTE = 3'd1, GATE = 3'd2, RETURN = 3'd3, DONE = 3'd4;
    localparam int MAXC = SETTLE_CYCLES > DWELL_CYCLES ? SETTLE_CYCLES : DWELL_CYCLES;
    localparam int TW = $clog2(MAXC + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [TW-1:0] S_LAST = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] D_LAST = TW'(DWELL_CYCLES - 1);
    logic [2:0] state, nxt_state;
    logic [TW-1:0] timer, nxt_timer;
    logic [1:0] cmd, nxt_cmd, head;
    logic aborted, nxt_aborted;
    logic [7:0] nxt_sv1, nxt_sv2, nxt_sv3;
    logic [1:0] mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic push, pop, s_end, d_end;
    assign cmd_ready = fifo_count < 3'(FIFO_DEPTH) && !abort;
    assign push = cmd_valid && cmd_ready;
    assign pop = state == IDLE && fifo_count != 3'd0 && !abort;
    assign head = mem[rd_ptr];
    assign s_end = timer == S_LAST;
    assign d_end = timer == D_LAST;
    assign state_code = {1'b0, state};
    // next-state, timer and servo targets; cmd[0] picks the tower, cmd[1] dispense vs recycle
    always_comb begin
        nxt_state = state;
        nxt_timer = timer + 1'b1;
        nxt_cmd = cmd;
        nxt_aborted = aborted;
        nxt_sv1 = sv1_pos;
        nxt_sv2 = sv2_pos;
        nxt_sv3 = sv3_pos;
        case (state)
            IDLE: begin
                nxt_timer = '0;
                if (pop) begin
                    nxt_state = ROUTE;
                    nxt_cmd = head;
                    nxt_aborted = 1'b0;
                    nxt_sv1 = head[0] ? TOW2 : TOW1;
                    nxt_sv2 = HOME;
                    nxt_sv3 = HOME;
                end
            end
            ROUTE: begin
                if (abort || s_end) begin
                    nxt_timer = '0;
                    nxt_state = abort ? RETURN : GATE;
                    nxt_aborted = abort;
                    nxt_sv1 = abort ? HOME : sv1_pos;
                    nxt_sv2 = abort || cmd[0] ? HOME : (cmd[1] ? DISP1 : RECYC1);
                    nxt_sv3 = abort || !cmd[0] ? HOME : (cmd[1] ? DISP2 : RECYC2);
                end
            end
            GATE: begin
                if (abort || d_end) begin
                    nxt_timer = '0;
                    nxt_state = RETURN;
                    nxt_aborted = abort;
                    nxt_sv1 = HOME;
                    nxt_sv2 = HOME;
                    nxt_sv3 = HOME;
                end
            end
            RETURN: begin
                nxt_aborted = aborted || abort;
                if (s_end) nxt_state = nxt_aborted ? IDLE : DONE;
            end
            default: nxt_state = IDLE;
        endcase
    end
    // sequencer registers; busy and done are registered from the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            timer <= '0;
            cmd <= '0;
            aborted <= 1'b0;
            sv1_pos <= HOME;
            sv2_pos <= HOME;
            sv3_pos <= HOME;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= nxt_state;
            timer <= nxt_timer;
            cmd <= nxt_cmd;
            aborted <= nxt_aborted;
            sv1_pos <= nxt_sv1;
            sv2_pos <= nxt_sv2;
            sv3_pos <= nxt_sv3;
            busy <= nxt_state != IDLE;
            done <= nxt_state == DONE;
        end
    end
    // queue pointers and occupancy; abort flushes, and blocks push via cmd_ready and pop via pop
    always_ff @(posedge clk) begin
        if (!rst_n || abort) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            fifo_count <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(push);
            rd_ptr <= rd_ptr + PW'(pop);
            fifo_count <= fifo_count + 3'(push) - 3'(pop);
        end
    end
    // queue storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= cmd_data;
    end
endmodule

// File: tb/tb_dispense_sequencer.sv
// tb_dispense_sequencer: directed checks of queueing, timing, abort and reset
module tb_dispense_sequencer;
    logic clk = 1'b0;
    logic rst_n, cmd_valid, abort, cmd_ready, busy, done;
    logic [1:0] cmd_data;
    logic [7:0] sv1_pos, sv2_pos, sv3_pos;
    logic [2:0] fifo_count;
    logic [3:0] state_code;
    int errors = 0;
    int checks = 0;
    dispense_sequencer #(.SETTLE_CYCLES(4), .DWELL_CYCLES(6), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
        .cmd_ready(cmd_ready), .abort(abort), .sv1_pos(sv1_pos), .sv2_pos(sv2_pos),
        .sv3_pos(sv3_pos), .busy(busy), .done(done), .fifo_count(fifo_count),
        .state_code(state_code)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
    initial begin
        logic [1:0] seq [4];
        logic [15:0] gates [4];
        int done_at [8];
        int ng, nd, w, dn;
        logic [3:0] prev;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_data = 2'b00;
        abort = 1'b0;
        tick(2);
        check("rst_pos", {sv1_pos, sv2_pos, sv3_pos}, 24'h888888);
        check("rst_flags", {busy, done, cmd_ready}, 3'b001);
        check("rst_count", fifo_count, 0);
        check("rst_state", state_code, 0);
        rst_n = 1'b1;
        tick(1);
        cmd_valid = 1'b1;
        cmd_data = 2'b10;
        tick(1);
        cmd_valid = 1'b0;
        check("t1_queued", fifo_count, 1);
        check("t1_idle", state_code, 0);
        tick(1);
        check("t1_route", {state_code, sv1_pos}, {4'd1, 8'h40});
        check("t1_busy", {busy, fifo_count}, {1'b1, 3'd0});
        tick(3);
        check("t1_route_end", state_code, 1);
        tick(1);
        check("t1_gate", {state_code, sv1_pos, sv2_pos, sv3_pos}, {4'd2, 24'h40FF88});
        tick(6);
        check("t1_return", {state_code, sv1_pos, sv2_pos, sv3_pos}, {4'd3, 24'h888888});
        tick(3);
        check("t1_no_done_early", done, 0);
        tick(1);
        check("t1_done", {state_code, done, busy}, {4'd4, 2'b11});
        tick(1);
        check("t1_idle_after", {state_code, done, busy}, {4'd0, 2'b00});
        seq = '{2'b10, 2'b11, 2'b00, 2'b01};
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_data = seq[i];
            tick(1);
        end
        cmd_valid = 1'b0;
        check("b2b_count", {fifo_count, cmd_ready}, {3'd3, 1'b1});
        ng = 0;
        nd = 0;
        for (int i = 0; i < 90; i++) begin
            prev = state_code;
            tick(1);
            if (state_code == 2 && prev != 2 && ng < 4) begin
                gates[ng] = {sv2_pos, sv3_pos};
                ng++;
            end
            if (done && nd < 8) begin
                done_at[nd] = i;
                nd++;
            end
        end
        check("b2b_gate_entries", ng, 4);
        check("b2b_done_count", nd, 4);
        check("b2b_gate0", gates[0], 16'hFF88);
        check("b2b_gate1", gates[1], 16'h8800);
        check("b2b_gate2", gates[2], 16'h0088);
        check("b2b_gate3", gates[3], 16'h88FF);
        for (int k = 1; k < 4; k++) check("b2b_done_gap", done_at[k] - done_at[k-1], 16);
        check("b2b_end", {state_code, fifo_count}, {4'd0, 3'd0});
        seq = '{2'b00, 2'b01, 2'b11, 2'b10};
        cmd_valid = 1'b1;
        cmd_data = 2'b10;
        tick(1);
        for (int i = 0; i < 4; i++) begin
            cmd_data = seq[i];
            tick(1);
        end
        cmd_data = 2'b11;
        check("full_count", {fifo_count, cmd_ready}, {3'd4, 1'b0});
        tick(3);
        check("full_held", {fifo_count, cmd_ready}, {3'd4, 1'b0});
        w = 0;
        while (fifo_count == 4 && w < 40) begin
            tick(1);
            w++;
        end
        check("full_drop", {fifo_count, cmd_ready, state_code}, {3'd3, 1'b1, 4'd1});
        tick(1);
        cmd_valid = 1'b0;
        check("full_accept", fifo_count, 4);
        abort = 1'b1;
        #1;
        check("abort_ready_low", cmd_ready, 0);
        tick(1);
        abort = 1'b0;
        check("full_flush", {state_code, fifo_count}, {4'd3, 3'd0});
        tick(4);
        check("full_cleanup", {state_code, fifo_count, busy}, {4'd0, 3'd0, 1'b0});
        cmd_valid = 1'b1;
        cmd_data = 2'b01;
        tick(1);
        cmd_data = 2'b10;
        tick(1);
        cmd_data = 2'b11;
        tick(1);
        cmd_valid = 1'b0;
        tick(3);
        check("ab_gate", {state_code, sv1_pos, sv2_pos, sv3_pos}, {4'd2, 24'hC088FF});
        check("ab_queued", fifo_count, 2);
        tick(1);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("ab_return", {state_code, sv1_pos, sv2_pos, sv3_pos}, {4'd3, 24'h888888});
        check("ab_flushed", {fifo_count, done}, {3'd0, 1'b0});
        dn = 0;
        tick(3);
        dn += int'(done);
        check("ab_return_hold", state_code, 3);
        tick(1);
        dn += int'(done);
        check("ab_idle", {state_code, busy}, {4'd0, 1'b0});
        tick(2);
        dn += int'(done);
        check("ab_no_done", dn, 0);
        check("ab_stays_idle", {state_code, fifo_count}, {4'd0, 3'd0});
        cmd_valid = 1'b1;
        cmd_data = 2'b01;
        tick(1);
        cmd_data = 2'b10;
        tick(1);
        cmd_valid = 1'b0;
        tick(4);
        check("rm_gate", {state_code, sv3_pos, fifo_count}, {4'd2, 8'hFF, 3'd1});
        rst_n = 1'b0;
        tick(1);
        check("rm_pos", {sv1_pos, sv2_pos, sv3_pos}, 24'h888888);
        check("rm_state", {state_code, fifo_count, busy, done}, {4'd0, 3'd0, 2'b00});
        rst_n = 1'b1;
        tick(1);
        check("rm_after", {state_code, fifo_count}, {4'd0, 3'd0});
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
